// File: rtl/render_cmd_loader_if.sv
// render_cmd_loader_if: VALID/READY command word stream into the loader
interface render_cmd_loader_if #(parameter int DW = 8);
    logic [DW-1:0] DATA;
    logic          VALID;
    logic          READY;
    modport master (output DATA, VALID, input READY);
    modport slave  (input DATA, VALID, output READY);
endinterface

// File: rtl/render_cmd_loader.sv
// render_cmd_loader: loads a header+operand stream into a register file and hands it to the draw engine.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum word on every command.
module render_cmd_loader #(
    parameter int DW       = 8,
    parameter int MAX_REGS = 8,
    parameter int LEN_BITS = 3
) (
    input  logic                   ACLK,
    input  logic                   RESETn,
    render_cmd_loader_if.slave     s,
    input  logic                   ARM,
    input  logic                   ENB,
    output logic [MAX_REGS*DW-1:0] CMD_REGS,
    output logic [LEN_BITS-1:0]    CMD_LEN,
    output logic                   DRAW_START,
    input  logic                   DRAW_DONE,
    output logic                   FINISH_READ,
    output logic                   FINISH_WRITE,
    output logic                   BUSY,
    output logic                   CMD_ERR
);
    localparam int CW = LEN_BITS + 1;
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, ISSUE, WAIT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count, n;
    logic xfer, hdr, ovf, wr, last, sum_ok, err_set, arm_go;
    logic fr_nx, fw_nx, ds_nx;
    assign s.READY = state == LOAD || state == DRAIN;
    assign BUSY    = state != IDLE;
    assign xfer    = s.VALID && s.READY;
    assign arm_go  = state == IDLE && ARM;
    assign hdr     = count == '0;
    // while the header is on the bus, its length field is not registered yet
    assign n       = hdr ? CW'(s.DATA[LEN_BITS-1:0]) : CW'(CMD_LEN);
    assign ovf     = state == LOAD && xfer && hdr && n > CW'(MAX_REGS - 1);
    assign wr      = state == LOAD && xfer && count <= n;
`ifdef CMD_CHECKSUM_EN
    logic [DW-1:0] csum;
    assign last   = state == LOAD && xfer && count == n + 1'b1;
    assign sum_ok = s.DATA == csum;
`else
    assign last   = state == LOAD && xfer && count == n;
    assign sum_ok = 1'b1;
`endif
    assign err_set = ovf || (last && !sum_ok);

    always_ff @(posedge ACLK or negedge RESETn)
        if (!RESETn) state <= IDLE;
        else         state <= state_nx;

    always_comb begin
        state_nx = state;
        fr_nx    = 1'b0;
        fw_nx    = 1'b0;
        ds_nx    = 1'b0;
        case (state)
            IDLE:  if (ARM) state_nx = LOAD;
            LOAD:
                if (ovf) state_nx = DRAIN;
                else if (last) begin
                    fr_nx    = 1'b1;
                    fw_nx    = sum_ok && n == '0;
                    state_nx = (sum_ok && n != '0) ? ISSUE : IDLE;
                end
            DRAIN:
                if (xfer && count == CW'(CMD_LEN)) begin
                    fr_nx    = 1'b1;
                    state_nx = IDLE;
                end
            ISSUE:
                if (ENB) begin
                    ds_nx    = 1'b1;
                    state_nx = WAIT;
                end
            WAIT:
                if (DRAW_DONE) begin
                    fw_nx    = 1'b1;
                    state_nx = IDLE;
                end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge RESETn)
        if (!RESETn) begin
            count        <= '0;
            CMD_REGS     <= '0;
            CMD_LEN      <= '0;
            CMD_ERR      <= 1'b0;
            FINISH_READ  <= 1'b0;
            FINISH_WRITE <= 1'b0;
            DRAW_START   <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            FINISH_READ  <= fr_nx;
            FINISH_WRITE <= fw_nx;
            DRAW_START   <= ds_nx;
            if (arm_go) begin
                count    <= '0;
                CMD_REGS <= '0;
                CMD_ERR  <= 1'b0;
`ifdef CMD_CHECKSUM_EN
                csum     <= '0;
`endif
            end else begin
                if (xfer) count <= count + 1'b1;
                if (wr && hdr) CMD_LEN <= s.DATA[LEN_BITS-1:0];
                for (int k = 0; k < MAX_REGS; k++)
                    if (wr && count == CW'(k)) CMD_REGS[k*DW +: DW] <= s.DATA;
                if (err_set) CMD_ERR <= 1'b1;
`ifdef CMD_CHECKSUM_EN
                if (wr) csum <= csum ^ s.DATA;
`endif
            end
        end
endmodule
